// File: rtl/half_pel_serializer_if.sv
// Segment input and sample output handshake bundle of the half-pel serializer.
interface half_pel_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] cur_pix;
    logic [55:0] filter_pix;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;
    logic        out_half;
    logic        out_last;

    // slave: the serializer itself; master: the environment driving it.
    modport slave (
        input  in_valid, cur_pix, filter_pix, out_ready,
        output in_ready, out_valid, out_pix, out_half, out_last
    );
    modport master (
        output in_valid, cur_pix, filter_pix, out_ready,
        input  in_ready, out_valid, out_pix, out_half, out_last
    );
endinterface

// File: rtl/half_pel_serializer.sv
// Interleaves 8 integer pixels and 7 half-pel averages into a 15-beat sample
// stream, with a two-deep segment buffer and a per-line last-sample flag.
module half_pel_serializer #(
    parameter int unsigned SEGS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    half_pel_serializer_if.slave  bus
);
    localparam int unsigned SEG_DW   = 120;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned SEG_W    = (SEGS_PER_LINE > 1) ? $clog2(SEGS_PER_LINE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(14);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGS_PER_LINE - 1);

    typedef enum logic {S_EMPTY, S_SHIFT} state_t;

    state_t              r_state, w_state_nxt;
    logic [SEG_DW-1:0]   r_act, w_act_nxt;
    logic [SEG_DW-1:0]   r_pend, w_pend_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [SEG_W-1:0]    r_seg, w_seg_nxt;
    logic                r_in_ready;
    logic [7:0]          r_out_pix, w_out_pix_nxt;
    logic                r_out_half, w_out_half_nxt;
    logic                r_out_last, w_out_last_nxt;

    logic [SEG_DW-1:0]   w_in_seg;
    logic                w_accept;
    logic                w_fire;
    logic                w_finish;

    // Segment layout: integer pixels in [63:0], half-pel samples in [119:64].
    function automatic logic [7:0] sel_sample(input logic [SEG_DW-1:0] d,
                                              input logic [IDX_W-1:0]  k);
        logic [7:0] s;
        s = '0;
        for (int j = 0; j < 8; j++)
            if (!k[0] && (k[3:1] == 3'(j))) s = d[8*j +: 8];
        for (int j = 0; j < 7; j++)
            if (k[0] && (k[3:1] == 3'(j))) s = d[64 + 8*j +: 8];
        return s;
    endfunction

    assign w_in_seg = {bus.filter_pix, bus.cur_pix};
    assign w_accept = bus.in_valid & r_in_ready;
    assign w_fire   = (r_state == S_SHIFT) & bus.out_ready;
    assign w_finish = w_fire & (r_idx == IDX_LAST);

    // Next-state for the active slot, pending slot, beat index and line position.
    always_comb begin
        w_state_nxt      = r_state;
        w_act_nxt        = r_act;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_idx_nxt        = r_idx;
        w_seg_nxt        = r_seg;

        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                    w_act_nxt   = w_in_seg;
                    w_idx_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (w_fire && !w_finish) w_idx_nxt = r_idx + IDX_W'(1);
                if (w_finish) begin
                    w_seg_nxt = (r_seg == SEG_LAST) ? '0 : r_seg + SEG_W'(1);
                    w_idx_nxt = '0;
                    if (r_pend_valid) begin
                        w_act_nxt        = r_pend;
                        w_pend_valid_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_act_nxt = w_in_seg;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end else if (w_accept) begin
                    w_pend_nxt       = w_in_seg;
                    w_pend_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase

        w_out_pix_nxt  = '0;
        w_out_half_nxt = 1'b0;
        w_out_last_nxt = 1'b0;
        if (w_state_nxt == S_SHIFT) begin
            w_out_pix_nxt  = sel_sample(w_act_nxt, w_idx_nxt);
            w_out_half_nxt = w_idx_nxt[0];
            w_out_last_nxt = (w_idx_nxt == IDX_LAST) && (w_seg_nxt == SEG_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_act        <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_idx        <= '0;
            r_seg        <= '0;
            r_in_ready   <= 1'b1;
            r_out_pix    <= '0;
            r_out_half   <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_act        <= w_act_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_idx        <= w_idx_nxt;
            r_seg        <= w_seg_nxt;
            r_in_ready   <= !w_pend_valid_nxt;
            r_out_pix    <= w_out_pix_nxt;
            r_out_half   <= w_out_half_nxt;
            r_out_last   <= w_out_last_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state == S_SHIFT);
    assign bus.out_pix   = r_out_pix;
    assign bus.out_half  = r_out_half;
    assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_half_pel_serializer.sv
// Scoreboard bench for half_pel_serializer: expected samples are queued on each
// accepted segment and compared on each output handshake.
module tb_half_pel_serializer;
    localparam int unsigned SPL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    half_pel_serializer_if bus();

    half_pel_serializer #(.SEGS_PER_LINE(SPL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {last, half, pix}
    logic [9:0] q[$];
    int         m_seg = 0;
    int         pops = 0;
    int         lasts_seen = 0;
    int         run = 0;
    int         max_run = 0;
    int         rmode = 0;
    int         phase = 0;

    logic       held = 1'b0;
    logic [9:0] held_val;

    // Monitor: scoreboard push on accept, pop on output, hold-rule tracking.
    always @(negedge clk) begin
        logic [9:0]  e;
        logic [63:0] c;
        logic [55:0] f;
        if (rst) begin
            held = 1'b0;
            run  = 0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'({bus.out_last, bus.out_half, bus.out_pix}), 32'(held_val));
            end
            if (bus.out_valid) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sample", 32'({bus.out_last, bus.out_half, bus.out_pix}), 32'(e));
                end
                pops++;
                if (bus.out_last) lasts_seen++;
            end
            held = bus.out_valid && !bus.out_ready;
            held_val = {bus.out_last, bus.out_half, bus.out_pix};
            if (bus.in_valid && bus.in_ready) begin
                c = bus.cur_pix;
                f = bus.filter_pix;
                for (int k = 0; k < 15; k++) begin
                    e[7:0] = (k % 2 == 0) ? c[8*(k/2) +: 8] : f[8*(k/2) +: 8];
                    e[8]   = (k % 2 == 1);
                    e[9]   = (k == 14) && (m_seg == int'(SPL) - 1);
                    q.push_back(e);
                end
                m_seg = (m_seg + 1) % int'(SPL);
            end
        end
    end

    // out_ready driver: 0 = always high, 1 = pattern 1,0,0, 2 = random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin bus.out_ready = (phase == 0); phase = (phase + 1) % 3; end
                2: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Caller is aligned just after a posedge; returns just after the accepting posedge.
    task automatic send_seg(input logic [63:0] c, input logic [55:0] f);
        logic ok;
        ok = 1'b0;
        bus.in_valid   = 1'b1;
        bus.cur_pix    = c;
        bus.filter_pix = f;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        m_seg = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_pix"},   32'(bus.out_pix),   32'd0);
        check({tag, "_out_half"},  32'(bus.out_half),  32'd0);
        check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.cur_pix    = '0;
        bus.filter_pix = '0;
        @(posedge clk);
        #1;
        do_reset();
        check_reset_outputs("reset");

        // Single segment, latency to int0 and drop of out_valid afterwards.
        rmode = 0;
        send_seg(64'h0706050403020100, 56'h1A191817161514);
        @(negedge clk);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("latency_int0", 32'(bus.out_pix), 32'h00);
        @(posedge clk);
        #1;
        wait_drain();
        check("single_pops", 32'(pops), 32'd15);
        check("single_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure pattern 1,0,0.
        rmode = 1;
        pops  = 0;
        send_seg(64'h0706050403020100, 56'h1A191817161514);
        wait_drain();
        check("bp_pops", 32'(pops), 32'd15);

        // Back-to-back: two accepts fill the buffer, 45 beats without a bubble.
        rmode   = 0;
        pops    = 0;
        max_run = 0;
        send_seg(64'h1111111111111111, 56'h22222222222222);
        send_seg(64'h3333333333333333, 56'h44444444444444);
        @(negedge clk);
        check("b2b_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        send_seg(64'h5555555555555555, 56'h66666666666666);
        wait_drain();
        check("b2b_pops", 32'(pops), 32'd45);
        check("b2b_run", 32'(max_run), 32'd45);

        // Line flag over 8 segments starting at seg 0.
        do_reset();
        lasts_seen = 0;
        for (int s = 0; s < 8; s++)
            send_seg({$urandom, $urandom}, {24'($urandom), $urandom});
        wait_drain();
        check("line_lasts", 32'(lasts_seen), 32'd2);

        // Reset mid-segment with pending full, then restart at int0 / seg 0.
        pops = 0;
        send_seg(64'hA7A6A5A4A3A2A1A0, 56'hB6B5B4B3B2B1B0);
        send_seg(64'hC7C6C5C4C3C2C1C0, 56'hD6D5D4D3D2D1D0);
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (pops >= 6) ok = 1'b1;
            end
            if (!ok) check("midrst_timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        m_seg = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        lasts_seen = 0;
        pops = 0;
        for (int s = 0; s < SPL; s++)
            send_seg({$urandom, $urandom}, {24'($urandom), $urandom});
        wait_drain();
        check("midrst_pops", 32'(pops), 32'(15 * SPL));
        check("midrst_lasts", 32'(lasts_seen), 32'd1);

        // Saturated data under random backpressure.
        rmode = 2;
        pops  = 0;
        send_seg({64{1'b1}}, {56{1'b1}});
        send_seg({64{1'b1}}, {56{1'b1}});
        wait_drain();
        check("sat_pops", 32'(pops), 32'd30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/half_pel_serializer.md
# half_pel_serializer

Takes one 8-pixel integer segment and the matching 7 half-pel averages produced by the half-pel filter, and emits them as a single interleaved 2x-upsampled pixel stream, one 8-bit sample per beat (int0, half0, int1, …, half6, int7). It sits on the consumer side of the half-pel filter, between the filter and the downstream line writer or comparator. It provides valid/ready handshakes on both sides, a two-deep segment buffer so segments can stream back-to-back, and a per-line position counter that flags the last sample of each line.

## Interface
- SEGS_PER_LINE, 4: segments per picture line; range 1..256.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  **synchronous, active-high reset.**
- in_valid  in  1  segment offered.
- in_ready  out  1  segment accepted when in_valid & in_ready.
- cur_pix  in  64  integer pixels; pixel i = cur_pix[8i+7:8i], i = 0..7.
- filter_pix  in  56  half-pel pixels; half j = filter_pix[8j+7:8j], j = 0..6; half j lies between pixel j and pixel j+1.
- out_valid  out  1  out_pix valid.
- out_ready  in  1  sample consumed when out_valid & out_ready.
- out_pix  out  8  current sample.
- out_half  out  1  1 when the current sample is a half-pel sample.
- out_last  out  1  1 on the final sample (int7) of the last segment of a line.

## Operation
- Storage: active register (120 bits + valid) and pending register (120 bits + valid). Beat index idx is 0..14. Segment counter seg is 0..SEGS_PER_LINE-1.
- Sample select: even idx = 2i → pixel i, out_half = 0. Odd idx = 2j+1 → half j, out_half = 1. No arithmetic is performed; samples pass through bit-exact.
- in_ready = !pending_valid. It is a combinational function of registered state only and never depends on out_ready.
- Active slot states:
  - EMPTY: active_valid = 0.
  - SHIFT: active_valid = 1.
- Transitions:
  - EMPTY → SHIFT on an accept, with idx = 0.
  - In SHIFT, an output handshake with idx < 14 increments idx.
  - In SHIFT, an output handshake with idx == 14 finishes the segment:
    - If pending is valid, pending moves to active and idx = 0, with no bubble.
    - Otherwise, if an accept occurs in the same cycle, the input goes directly to active and idx = 0.
    - Otherwise, the slot returns to EMPTY.
- Accept routing:
  - Input goes to active when active is EMPTY, or when it is finishing this cycle and pending is empty.
  - Otherwise input goes to pending.
  - Pending is never overwritten while valid.
- out_last = active_valid & (idx == 14) & (seg == SEGS_PER_LINE-1).
- seg increments on each finished segment and wraps to 0 after the last segment of a line.
- Hold rule: while out_valid & !out_ready, out_pix, out_half and out_last stay stable.
- Reset (any cycle, including mid-segment):
  - active_valid = 0, pending_valid = 0, idx = 0, seg = 0.
  - out_valid = 0, out_pix = 0, out_half = 0, out_last = 0.
  - in_ready = 1 in the first cycle after reset.
  - Partially sent segments are discarded.

## Timing
- Latency: a segment accepted at edge t presents int0 with out_valid = 1 in the cycle after t. out_pix is driven from registered state.
- Throughput with out_ready held high: 15 samples per segment, one per cycle. Back-to-back segments run with no idle cycle when the next segment is already pending or arrives on the finishing cycle.
- Maximum stored segments: 2. With out_ready low indefinitely, the second accepted segment drives in_ready low until the first segment finishes.
- out_valid = active_valid. It may not drop until idx-14 handshake completes.
- A simultaneous accept and idx-14 handshake with pending empty is legal and must produce no gap and no loss.

## Test plan
- Single segment: cur_pix = 0x0706050403020100, filter_pix = 0x1A191817161514, out_ready = 1.
  - Expected out_pix sequence: 00,14,01,15,02,16,03,17,04,18,05,19,06,1A,07.
  - Expected out_half pattern: 0,1,0,1,…,0.
  - out_valid drops after 15 beats.
- Backpressure: same segment with out_ready toggling 1,0,0,1,…
  - Each sample is held stable while out_ready = 0.
  - All 15 samples arrive in order, with no duplicates.
- Back-to-back: offer 3 segments on consecutive cycles with out_ready = 1.
  - in_ready goes low after 2 accepts.
  - Exactly 45 consecutive valid beats, with no bubble between segments.
- Line flag: SEGS_PER_LINE = 4, stream 8 segments.
  - out_last = 1 only on beat 14 of segments 3 and 7.
- Reset mid-stream: assert rst at idx = 6 of segment 1 while pending is full.
  - Next cycle: out_valid = 0, in_ready = 1, all outputs 0.
  - The next segment then starts at int0 with seg = 0.
- Saturated data: cur_pix = all 0xFF, filter_pix = all 0xFF.
  - All 15 samples are 0xFF.
  - The out_half pattern is unchanged.
